max_pool_forward: RTL and testbench

//  2x2 / stride-2 max-pool forward pass over an fp32 tensor held in memory.

---
 rtl/max_pool_forward.sv | 261 ++++++++++++++++++++++++++
 tb/tb_max_pool_forward.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_forward.sv
// 2x2 / stride-2 max-pool forward over an fp32 CHW tensor in word-addressed memory.
// Optional feature macro: MAXP_FWD_IDX_EN (also writes the per-output argmax index k).
module max_pool_forward #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  output logic              done,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] idx_base,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  channels,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned DATA_W = 32;

`ifdef MAXP_FWD_IDX_EN
  typedef enum logic [2:0] {
    S_WAIT = 3'd0, S_RD = 3'd1, S_WV = 3'd2, S_WI = 3'd3, S_ADV = 3'd4, S_DONE = 3'd5
  } state_e;
  logic [ADDR_W-1:0] idx_base_q, idx_base_d;
`else
  typedef enum logic [2:0] {
    S_WAIT = 3'd0, S_RD = 3'd1, S_WV = 3'd2, S_ADV = 3'd4, S_DONE = 3'd5
  } state_e;
  logic unused_idx_base;
  assign unused_idx_base = ^idx_base;
`endif

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   in_base_q, in_base_d, out_base_q, out_base_d;
  logic [DIM_W-1:0]    h_q, h_d, w_q, w_d, oh_q, oh_d, ow_q, ow_d, nc_q, nc_d;
  logic [DIM_W-1:0]    ch_q, ch_d, oy_q, oy_d, ox_q, ox_d;
  logic [1:0]          k_q, k_d, kmax_q, kmax_d;
  logic [DATA_W-1:0]   max_q, max_d;

  logic                acc;
  logic [DATA_W-1:0]   new_max;
  logic [1:0]          new_kmax;
  logic                last_win;
  logic [ADDR_W-1:0]   out_off;

  assign done      = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Ordering key: NaNs collapse to the lowest rank, both zeros share one key.
  function automatic logic [32:0] fkey(input logic [31:0] v);
    if (v[30:23] == 8'hFF && v[22:0] != 23'd0) return 33'd0;
    if (v[30:0] == 31'd0) return {1'b1, 32'h8000_0000};
    return {1'b1, v[31] ? ~v : (v | 32'h8000_0000)};
  endfunction

  // Word address of window element k for output position (c, oy, ox).
  function automatic logic [ADDR_W-1:0] in_addr(input logic [DIM_W-1:0] c, input logic [DIM_W-1:0] oy,
                                                 input logic [DIM_W-1:0] ox, input logic [1:0] k);
    logic [ADDR_W-1:0] y, x;
    y = ADDR_W'({oy, k[1]});
    x = ADDR_W'({ox, k[0]});
    return in_base_q + (ADDR_W'(c) * ADDR_W'(h_q) + y) * ADDR_W'(w_q) + x;
  endfunction

  // State, outputs, latched operands and counters.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= S_WAIT;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      h_q        <= '0;
      w_q        <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      nc_q       <= '0;
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      k_q        <= '0;
      kmax_q     <= '0;
      max_q      <= '0;
`ifdef MAXP_FWD_IDX_EN
      idx_base_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      h_q        <= h_d;
      w_q        <= w_d;
      oh_q       <= oh_d;
      ow_q       <= ow_d;
      nc_q       <= nc_d;
      ch_q       <= ch_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      k_q        <= k_d;
      kmax_q     <= kmax_d;
      max_q      <= max_d;
`ifdef MAXP_FWD_IDX_EN
      idx_base_q <= idx_base_d;
`endif
    end
  end

  // Next-state, memory sequencing and running-max update.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    h_d        = h_q;
    w_d        = w_q;
    oh_d       = oh_q;
    ow_d       = ow_q;
    nc_d       = nc_q;
    ch_d       = ch_q;
    oy_d       = oy_q;
    ox_d       = ox_q;
    k_d        = k_q;
    kmax_d     = kmax_q;
    max_d      = max_q;
    last_win   = 1'b0;
`ifdef MAXP_FWD_IDX_EN
    idx_base_d = idx_base_q;
`endif

    acc      = req_q & mem_ack;
    out_off  = (ADDR_W'(ch_q) * ADDR_W'(oh_q) + ADDR_W'(oy_q)) * ADDR_W'(ow_q) + ADDR_W'(ox_q);
    new_max  = max_q;
    new_kmax = kmax_q;
    if (k_q == 2'd0 || fkey(mem_rdata) > fkey(max_q)) begin
      new_max  = mem_rdata;
      new_kmax = k_q;
    end

    case (state_q)
      S_WAIT: begin
        if (go) begin
          in_base_d  = in_base;
          out_base_d = out_base;
`ifdef MAXP_FWD_IDX_EN
          idx_base_d = idx_base;
`endif
          h_d  = height;
          w_d  = width;
          oh_d = height >> 1;
          ow_d = width >> 1;
          nc_d = channels;
          ch_d = '0;
          oy_d = '0;
          ox_d = '0;
          k_d  = '0;
          if ((height >> 1) == '0 || (width >> 1) == '0 || channels == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = in_base;
          end
        end
      end
      S_RD: begin
        if (acc) begin
          max_d  = new_max;
          kmax_d = new_kmax;
          if (k_q != 2'd3) begin
            k_d    = k_q + 2'd1;
            addr_d = in_addr(ch_q, oy_q, ox_q, k_q + 2'd1);
          end else begin
            k_d     = 2'd0;
            state_d = S_WV;
            we_d    = 1'b1;
            addr_d  = out_base_q + out_off;
            wdata_d = new_max;
          end
        end
      end
      S_WV: begin
        if (acc) begin
`ifdef MAXP_FWD_IDX_EN
          state_d = S_WI;
          addr_d  = idx_base_q + out_off;
          wdata_d = DATA_W'(kmax_q);
`else
          state_d = S_ADV;
          req_d   = 1'b0;
          we_d    = 1'b0;
`endif
        end
      end
`ifdef MAXP_FWD_IDX_EN
      S_WI: begin
        if (acc) begin
          state_d = S_ADV;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
`endif
      S_ADV: begin
        if (ox_q == ow_q - DIM_W'(1)) begin
          ox_d = '0;
          if (oy_q == oh_q - DIM_W'(1)) begin
            oy_d = '0;
            if (ch_q == nc_q - DIM_W'(1)) last_win = 1'b1;
            else ch_d = ch_q + DIM_W'(1);
          end else begin
            oy_d = oy_q + DIM_W'(1);
          end
        end else begin
          ox_d = ox_q + DIM_W'(1);
        end
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = in_addr(ch_d, oy_d, ox_d, 2'd0);
        end
      end
      S_DONE: begin
        if (!go) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase

    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_max_pool_forward.sv
// Directed bench for max_pool_forward with a word memory model and optional random ack delay.
module tb_max_pool_forward;

`ifdef MAXP_FWD_IDX_EN
  localparam int IDX = 1;
`else
  localparam int IDX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic        go;
  logic        done;
  logic [31:0] in_base, out_base, idx_base;
  logic [15:0] height, width, channels;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] in_mem  [0:1023];
  logic [31:0] out_mem [0:1023];
  int          wcnt, cur_dly, n_rd, n_wr, hs_viol, bad_addr;
  bit          rnd_mode;
  logic        pend, p_we;
  logic [31:0] p_addr, p_wdata;
  int          n_chk, n_fail;

  always #5 clk = ~clk;

  max_pool_forward dut (
    .clk(clk), .rst_l(rst_l), .go(go), .done(done),
    .in_base(in_base), .out_base(out_base), .idx_base(idx_base),
    .height(height), .width(width), .channels(channels),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assign mem_ack   = mem_req && (wcnt == cur_dly);
  assign mem_rdata = in_mem[mem_addr[9:0]];

  // Memory model: completes accesses after the chosen delay.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wcnt <= 0;
    end else if (mem_req) begin
      if (mem_addr >= 32'd1024) bad_addr <= bad_addr + 1;
      if (mem_ack) begin
        wcnt    <= 0;
        cur_dly <= rnd_mode ? int'($urandom_range(0, 5)) : 0;
        if (mem_we) begin
          out_mem[mem_addr[9:0]] <= mem_wdata;
          n_wr <= n_wr + 1;
        end else begin
          n_rd <= n_rd + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Request fields must hold until the access completes.
  always @(posedge clk) begin
    if (!rst_l) begin
      pend <= 1'b0;
    end else begin
      if (pend && (mem_req !== 1'b1 || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata))
        hs_viol <= hs_viol + 1;
      pend    <= mem_req && !mem_ack;
      p_we    <= mem_we;
      p_addr  <= mem_addr;
      p_wdata <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int2f(input int v);
    int e;
    logic [31:0] sh;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    sh = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), sh[22:0]};
  endfunction

  // Start one operation, scramble the operand inputs, wait for done and release go.
  task automatic run_op(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] xb,
                        input logic [15:0] h, input logic [15:0] w, input logic [15:0] c,
                        output int cyc);
    @(negedge clk);
    in_base = ib; out_base = ob; idx_base = xb;
    height = h; width = w; channels = c; go = 1'b1;
    @(negedge clk);
    cyc = 1;
    in_base = 32'h3F0; out_base = 32'h3F0; idx_base = 32'h3F8;
    height = 16'd7; width = 16'd9; channels = 16'd3;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("op_done", 32'(done), 32'd1);
    go = 1'b0;
    @(negedge clk);
    check("op_done_clr", 32'(done), 32'd0);
  endtask

  int cyc, rd0, wr0, guard;
  logic [31:0] exp2 [0:7];
  logic [31:0] t4   [0:7];

  initial begin
    n_chk = 0; n_fail = 0; n_rd = 0; n_wr = 0; hs_viol = 0; bad_addr = 0;
    wcnt = 0; cur_dly = 0; rnd_mode = 1'b0;
    go = 1'b0; in_base = '0; out_base = '0; idx_base = '0;
    height = '0; width = '0; channels = '0;
    for (int i = 0; i < 1024; i++) in_mem[i] = 32'h0;
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst_l = 1'b1;

    // 1: single window, max is 3.0 at k=1
    in_mem[512] = 32'h3F800000; in_mem[513] = 32'h40400000;
    in_mem[514] = 32'h40000000; in_mem[515] = 32'hBF800000;
    rd0 = n_rd; wr0 = n_wr;
    run_op(32'd512, 32'h000, 32'h100, 16'd2, 16'd2, 16'd1, cyc);
    check("t1_out", out_mem[0], 32'h40400000);
    check("t1_cycles", 32'(cyc), 32'(1 + 6 + IDX));
    check("t1_reads", 32'(n_rd - rd0), 32'd4);
    check("t1_writes", 32'(n_wr - wr0), 32'(1 + IDX));
    if (IDX == 1) check("t1_idx", out_mem[256], 32'd1);

    // 2: C=2, 4x4, values 0..31
    for (int i = 0; i < 32; i++) in_mem[512 + i] = int2f(i);
    exp2[0] = int2f(5);  exp2[1] = int2f(7);  exp2[2] = int2f(13); exp2[3] = int2f(15);
    exp2[4] = int2f(21); exp2[5] = int2f(23); exp2[6] = int2f(29); exp2[7] = int2f(31);
    rd0 = n_rd; wr0 = n_wr;
    run_op(32'd512, 32'h010, 32'h110, 16'd4, 16'd4, 16'd2, cyc);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("t2_out%0d", j), out_mem[16 + j], exp2[j]);
      if (IDX == 1) check($sformatf("t2_idx%0d", j), out_mem[272 + j], 32'd3);
    end
    check("t2_cycles", 32'(cyc), 32'(1 + 8 * (6 + IDX)));
    check("t2_reads", 32'(n_rd - rd0), 32'd32);
    check("t2_writes", 32'(n_wr - wr0), 32'(8 * (1 + IDX)));

    // 3: H=3, W=5; row 2 and col 4 hold large values that must never be read
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 5; x++)
        in_mem[512 + y * 5 + x] = (y == 2 || x == 4) ? int2f(100) : int2f(y * 5 + x);
    rd0 = n_rd;
    run_op(32'd512, 32'h020, 32'h120, 16'd3, 16'd5, 16'd1, cyc);
    check("t3_out0", out_mem[32], int2f(6));
    check("t3_out1", out_mem[33], int2f(8));
    check("t3_reads", 32'(n_rd - rd0), 32'd8);

    // 4: signed zeros with a NaN, then an all-NaN window
    t4[0] = 32'h7FC00000; t4[1] = 32'h80000000; t4[2] = 32'h00000000; t4[3] = 32'hC0A00000;
    t4[4] = 32'h7FC00001; t4[5] = 32'hFF800001; t4[6] = 32'h7F800002; t4[7] = 32'h7FFFFFFF;
    for (int i = 0; i < 8; i++) in_mem[512 + i] = t4[i];
    run_op(32'd512, 32'h030, 32'h130, 16'd2, 16'd2, 16'd2, cyc);
    check("t4_zero", out_mem[48], 32'h80000000);
    check("t4_nan", out_mem[49], 32'h7FC00001);
    if (IDX == 1) begin
      check("t4_idx0", out_mem[304], 32'd1);
      check("t4_idx1", out_mem[305], 32'd0);
    end

    // 5: degenerate dims finish at once; held go keeps done
    rd0 = n_rd; wr0 = n_wr;
    run_op(32'd512, 32'h3C0, 32'h3C0, 16'd1, 16'd4, 16'd1, cyc);
    check("t5_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    height = 16'd4; width = 16'd4; channels = 16'd0; go = 1'b1;
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_hold", 32'(done), 32'd1);
    go = 1'b0;
    @(negedge clk);
    check("t5_release", 32'(done), 32'd0);
    check("t5_no_access", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);

    // 6: random ack delays, async abort, restart
    rnd_mode = 1'b1;
    for (int i = 0; i < 32; i++) in_mem[512 + i] = int2f(i);
    run_op(32'd512, 32'h040, 32'h140, 16'd4, 16'd4, 16'd2, cyc);
    for (int j = 0; j < 8; j++) check($sformatf("t6_out%0d", j), out_mem[64 + j], exp2[j]);
    rd0 = n_rd;
    @(negedge clk);
    in_base = 32'd512; out_base = 32'h050; idx_base = 32'h150;
    height = 16'd4; width = 16'd4; channels = 16'd2; go = 1'b1;
    guard = 0;
    while (n_rd - rd0 < 10 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("t6_progress", 32'(guard < 1000), 32'd1);
    wait (mem_req === 1'b1 && clk === 1'b0);
    #2 rst_l = 1'b0;
    #1;
    check("t6_abort_req", 32'(mem_req), 32'd0);
    check("t6_abort_done", 32'(done), 32'd0);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    in_mem[512] = 32'h3F800000; in_mem[513] = 32'h40400000;
    in_mem[514] = 32'h40000000; in_mem[515] = 32'hBF800000;
    run_op(32'd512, 32'h060, 32'h160, 16'd2, 16'd2, 16'd1, cyc);
    check("t6_restart", out_mem[96], 32'h40400000);
    if (IDX == 1) check("t6_restart_idx", out_mem[352], 32'd1);

    check("handshake_hold", 32'(hs_viol), 32'd0);
    check("addr_range", 32'(bad_addr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
